vga_timing_gen: RTL and testbench



---
 rtl/vga_timing_gen_pkg.sv | 32 +++
 rtl/vga_axis_counter.sv | 38 +++
 rtl/vga_timing_gen.sv | 71 +++++++
 tb/tb_vga_timing_gen.sv | 188 ++++++++++++++++++
 4 files changed

// File: rtl/vga_timing_gen_pkg.sv
// VGA overlay bus layout, shared by the timing source and the draw chain.
// Provides the bus width, field struct and merge/split helpers.
package vga_timing_gen_pkg;

  localparam int VGA_COORD_W  = 11;
  localparam int VGA_RGB_W    = 12;
  localparam int VGA_BUS_SIZE = 2 * VGA_COORD_W + 4 + VGA_RGB_W;

  // Field order, MSB first: hcount, hsync, hblnk, vcount, vsync, vblnk, rgb
  typedef struct packed {
    logic [VGA_COORD_W-1:0] hcount;
    logic                   hsync;
    logic                   hblnk;
    logic [VGA_COORD_W-1:0] vcount;
    logic                   vsync;
    logic                   vblnk;
    logic [VGA_RGB_W-1:0]   rgb;
  } vga_bus_t;

  function automatic int axis_total(int visible, int fp, int sync, int bp);
    return visible + fp + sync + bp;
  endfunction

  function automatic logic [VGA_BUS_SIZE-1:0] vga_bus_merge(vga_bus_t b);
    return b;
  endfunction

  function automatic vga_bus_t vga_bus_split(logic [VGA_BUS_SIZE-1:0] v);
    return v;
  endfunction

endpackage

// File: rtl/vga_axis_counter.sv
// One raster axis: free-running position counter with wrap, sync and blank decode.
// wrap/sync/blnk are combinational on count; the top registers them.
module vga_axis_counter
  import vga_timing_gen_pkg::*;
#(
  parameter int VISIBLE = 800,
  parameter int FP      = 40,
  parameter int SYNC    = 128,
  parameter int BP      = 88
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   inc,
  output logic [VGA_COORD_W-1:0] count,
  output logic                   wrap,
  output logic                   sync,
  output logic                   blnk
);

  localparam int TOTAL = axis_total(VISIBLE, FP, SYNC, BP);
  localparam logic [VGA_COORD_W-1:0] LAST       = VGA_COORD_W'(TOTAL - 1);
  localparam logic [VGA_COORD_W-1:0] VIS_END    = VGA_COORD_W'(VISIBLE);
  localparam logic [VGA_COORD_W-1:0] SYNC_START = VGA_COORD_W'(VISIBLE + FP);
  localparam logic [VGA_COORD_W-1:0] SYNC_END   = VGA_COORD_W'(VISIBLE + FP + SYNC);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      count <= '0;
    end else if (inc) begin
      count <= wrap ? '0 : count + VGA_COORD_W'(1);
    end
  end

  assign wrap = (count == LAST);
  assign sync = (count >= SYNC_START) && (count < SYNC_END);
  assign blnk = (count >= VIS_END);

endmodule

// File: rtl/vga_timing_gen.sv
// 800x600@60 raster source: drives the VGA overlay bus with black RGB,
// plus a last-pixel frame tick and a completed-frame counter.
module vga_timing_gen
  import vga_timing_gen_pkg::*;
#(
  parameter int H_VISIBLE = 800,
  parameter int H_FP      = 40,
  parameter int H_SYNC    = 128,
  parameter int H_BP      = 88,
  parameter int V_VISIBLE = 600,
  parameter int V_FP      = 1,
  parameter int V_SYNC    = 4,
  parameter int V_BP      = 23
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    en,
  output logic [VGA_BUS_SIZE-1:0] vga_out,
  output logic                    frame_tick,
  output logic [15:0]             frame_cnt
);

  logic [VGA_COORD_W-1:0] hc, vc;
  logic                   h_wrap, h_sync, h_blnk;
  logic                   v_wrap, v_sync, v_blnk;
  logic                   v_inc;
  vga_bus_t               bus_q;

  assign v_inc = en & h_wrap;

  vga_axis_counter #(
    .VISIBLE(H_VISIBLE), .FP(H_FP), .SYNC(H_SYNC), .BP(H_BP)
  ) u_h (
    .clk(clk), .rst(rst), .inc(en),
    .count(hc), .wrap(h_wrap), .sync(h_sync), .blnk(h_blnk)
  );

  vga_axis_counter #(
    .VISIBLE(V_VISIBLE), .FP(V_FP), .SYNC(V_SYNC), .BP(V_BP)
  ) u_v (
    .clk(clk), .rst(rst), .inc(v_inc),
    .count(vc), .wrap(v_wrap), .sync(v_sync), .blnk(v_blnk)
  );

  // Decode of the pre-increment position lands on the bus with the counters'
  // own edge, so the bus always trails the counters by one enabled cycle.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      bus_q      <= '0;
      frame_tick <= 1'b0;
      frame_cnt  <= '0;
    end else if (en) begin
      bus_q.hcount <= hc;
      bus_q.hsync  <= h_sync;
      bus_q.hblnk  <= h_blnk;
      bus_q.vcount <= vc;
      bus_q.vsync  <= v_sync;
      bus_q.vblnk  <= v_blnk;
      bus_q.rgb    <= '0;
      frame_tick   <= h_wrap & v_wrap;
      if (h_wrap && v_wrap) begin
        frame_cnt <= frame_cnt + 16'd1;
      end
    end else begin
      frame_tick <= 1'b0;
    end
  end

  assign vga_out = vga_bus_merge(bus_q);

endmodule

// File: tb/tb_vga_timing_gen.sv
// Bench: full-size instance for line-level timing, reduced-geometry instance
// for frame-level behaviour, both checked against an arithmetic raster model.
module tb_vga_timing_gen;
  import vga_timing_gen_pkg::*;

  localparam int SH_V = 20, SH_F = 3, SH_S = 5, SH_B = 4;
  localparam int SV_V = 10, SV_F = 1, SV_S = 2, SV_B = 3;
  localparam int S_HT = SH_V + SH_F + SH_S + SH_B;
  localparam int S_FRAME = S_HT * (SV_V + SV_F + SV_S + SV_B);
  localparam int B_FRAME = 1056 * 628;

  logic clk = 1'b0;
  logic rst_big, rst_sml, en_big, en_sml;
  logic [VGA_BUS_SIZE-1:0] out_big, out_sml;
  logic tick_big, tick_sml;
  logic [15:0] cnt_big, cnt_sml;

  int total = 0;
  int bad = 0;
  int n_big = 0, n_sml = 0;
  int base_sml = 0;
  vga_bus_t bb;

  always #5 clk = ~clk;

  vga_timing_gen dut_big (
    .clk(clk), .rst(rst_big), .en(en_big),
    .vga_out(out_big), .frame_tick(tick_big), .frame_cnt(cnt_big)
  );

  vga_timing_gen #(
    .H_VISIBLE(SH_V), .H_FP(SH_F), .H_SYNC(SH_S), .H_BP(SH_B),
    .V_VISIBLE(SV_V), .V_FP(SV_F), .V_SYNC(SV_S), .V_BP(SV_B)
  ) dut_sml (
    .clk(clk), .rst(rst_sml), .en(en_sml),
    .vga_out(out_sml), .frame_tick(tick_sml), .frame_cnt(cnt_sml)
  );

  // n = enabled edges since reset; edge n presents raster position n-1.
  function automatic logic [VGA_BUS_SIZE-1:0] model_bus(int n, int hv, int hf, int hs, int hb,
                                                        int vv, int vf, int vs, int vb);
    vga_bus_t b;
    int ht, vt, p, h, v;
    b = '0;
    if (n == 0) return b;
    ht = hv + hf + hs + hb;
    vt = vv + vf + vs + vb;
    p = (n - 1) % (ht * vt);
    h = p % ht;
    v = p / ht;
    b.hcount = 11'(h);
    b.vcount = 11'(v);
    b.hblnk  = (h >= hv);
    b.vblnk  = (v >= vv);
    b.hsync  = (h >= hv + hf) && (h < hv + hf + hs);
    b.vsync  = (v >= vv + vf) && (v < vv + vf + vs);
    b.rgb    = 12'h000;
    return b;
  endfunction

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic step(input logic eb, input logic es);
    logic tb_exp, ts_exp;
    en_big = eb;
    en_sml = es;
    @(posedge clk);
    #1;
    tb_exp = 1'b0;
    ts_exp = 1'b0;
    if (rst_big) n_big = 0;
    else if (eb) begin
      n_big++;
      tb_exp = (n_big % B_FRAME) == 0;
    end
    if (rst_sml) begin
      n_sml = 0;
      base_sml = 0;
    end else if (es) begin
      n_sml++;
      ts_exp = (n_sml % S_FRAME) == 0;
    end
    chk("big_bus", 64'(out_big), 64'(model_bus(n_big, 800, 40, 128, 88, 600, 1, 4, 23)));
    chk("big_tick", 64'(tick_big), 64'(tb_exp));
    chk("big_cnt", 64'(cnt_big), 64'((n_big / B_FRAME) & 16'hFFFF));
    chk("sml_bus", 64'(out_sml), 64'(model_bus(n_sml, SH_V, SH_F, SH_S, SH_B, SV_V, SV_F, SV_S, SV_B)));
    chk("sml_tick", 64'(tick_sml), 64'(ts_exp));
    chk("sml_cnt", 64'(cnt_sml), 64'((base_sml + n_sml / S_FRAME) & 16'hFFFF));
  endtask

  function automatic logic rnd_en();
    return $urandom_range(0, 3) != 0;
  endfunction

  initial begin
    int guard;
    rst_big = 1'b1;
    rst_sml = 1'b1;
    en_big = 1'b1;
    en_sml = 1'b1;
    #2;
    chk("reset_bus", 64'(out_big), 64'd0);
    chk("reset_tick", 64'(tick_big), 64'd0);
    step(1'b1, 1'b1);
    step(1'b1, 1'b1);
    rst_big = 1'b0;
    rst_sml = 1'b0;

    step(1'b1, 1'b1);
    bb = vga_bus_split(out_big);
    chk("first_hcount", 64'(bb.hcount), 64'd0);
    chk("first_vcount", 64'(bb.vcount), 64'd0);
    chk("first_hsync", 64'(bb.hsync), 64'd0);
    chk("first_hblnk", 64'(bb.hblnk), 64'd0);
    repeat (800) step(1'b1, rnd_en());
    bb = vga_bus_split(out_big);
    chk("edge801_hcount", 64'(bb.hcount), 64'd800);
    chk("edge801_hblnk", 64'(bb.hblnk), 64'd1);

    // Across the line wrap to presented hcount=500 on line 1.
    while (n_big < 1056 + 501) step(1'b1, rnd_en());
    repeat (7) step(1'b0, rnd_en());
    bb = vga_bus_split(out_big);
    chk("frozen_hcount", 64'(bb.hcount), 64'd500);
    chk("frozen_vcount", 64'(bb.vcount), 64'd1);
    step(1'b1, rnd_en());
    bb = vga_bus_split(out_big);
    chk("resume_hcount", 64'(bb.hcount), 64'd501);
    repeat (1200) step(rnd_en(), rnd_en());

    // Small instance: hold en off over the last pixel of a frame.
    guard = 0;
    while ((n_sml % S_FRAME) != S_FRAME - 1 && guard < 2 * S_FRAME) begin
      step(rnd_en(), 1'b1);
      guard++;
    end
    chk("wait_last_pixel_bound", 64'(guard < 2 * S_FRAME), 64'd1);
    repeat (3) step(rnd_en(), 1'b0);
    chk("held_tick", 64'(tick_sml), 64'd0);
    step(rnd_en(), 1'b1);
    chk("delayed_tick", 64'(tick_sml), 64'd1);
    chk("delayed_cnt", 64'(cnt_sml), 64'((n_sml / S_FRAME) & 16'hFFFF));

    // Async reset mid-frame at presented (12,7).
    guard = 0;
    while ((n_sml % S_FRAME) != 7 * S_HT + 13 && guard < 2 * S_FRAME) begin
      step(rnd_en(), 1'b1);
      guard++;
    end
    chk("wait_midframe_bound", 64'(guard < 2 * S_FRAME), 64'd1);
    rst_sml = 1'b1;
    #2;
    chk("async_rst_bus", 64'(out_sml), 64'd0);
    chk("async_rst_cnt", 64'(cnt_sml), 64'd0);
    chk("async_rst_tick", 64'(tick_sml), 64'd0);
    step(rnd_en(), 1'b1);
    rst_sml = 1'b0;
    step(rnd_en(), 1'b1);
    bb = vga_bus_split(out_sml);
    chk("restart_hcount", 64'(bb.hcount), 64'd0);
    chk("restart_vcount", 64'(bb.vcount), 64'd0);
    repeat (300) step(rnd_en(), rnd_en());

    // frame_cnt wrap from 16'hFFFF.
    dut_sml.frame_cnt = 16'hFFFF;
    base_sml = 16'hFFFF - (n_sml / S_FRAME);
    guard = 0;
    step(rnd_en(), 1'b1);
    while (tick_sml !== 1'b1 && guard < 2 * S_FRAME) begin
      step(rnd_en(), rnd_en());
      guard++;
    end
    chk("wrap_bound", 64'(guard < 2 * S_FRAME), 64'd1);
    chk("wrap_cnt", 64'(cnt_sml), 64'd0);
    chk("wrap_tick", 64'(tick_sml), 64'd1);
    repeat (600) step(rnd_en(), rnd_en());

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
